// File: rtl/shared_driver_arbiter_pkg.sv
// Shared types and helpers for the shared-driver arbiter.
package shared_driver_arbiter_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  // Index width with a floor of one bit, so the math also holds for tiny counts.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_driver_arbiter_if.sv
// Requester streams plus the single shared output net.
interface shared_driver_arbiter_if
  import shared_driver_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [IW-1:0]            out_src;
  logic                     out_ready;
  logic                     busy;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_src, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_src, busy
  );

endinterface

// File: rtl/shared_driver_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly after 'last', wrapping.
module rr_pick
  import shared_driver_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] pick
);

  int idx;

  // Scan from farthest to nearest so the nearest hit is the final assignment.
  always_comb begin
    any  = |req;
    pick = '0;
    idx  = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[IW'(idx)]) pick = IW'(idx);
    end
  end

endmodule

// File: rtl/shared_driver_arbiter.sv
// Round-robin owner of one high-fanout output net; grants last a packet or MAX_HOLD beats.
module shared_driver_arbiter
  import shared_driver_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input logic                   clk,
  input logic                   rst,
  shared_driver_arbiter_if.slave bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(MAX_HOLD + 1);

  state_t                         state;
  logic [IW-1:0]                  grant;
  logic [IW-1:0]                  last_grant;
  logic [CW-1:0]                  beat_cnt;
  logic                           any;
  logic [IW-1:0]                  pick;
  logic                           hs;
  logic                           rel;
  logic [NUM_REQ-1:0][WIDTH-1:0]  data_arr;

  assign data_arr = bus.req_data;
  assign hs  = (state == GRANT) && bus.req_valid[grant] && bus.out_ready;
  assign rel = hs && (bus.req_last[grant] || (beat_cnt == CW'(MAX_HOLD - 1)));

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (bus.req_valid),
    .last (last_grant),
    .any  (any),
    .pick (pick)
  );

  // Every release returns to IDLE, which gives the one-cycle bubble between owners.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          grant    <= pick;
          beat_cnt <= '0;
          state    <= GRANT;
        end
        GRANT: if (rel) begin
          last_grant <= grant;
          beat_cnt   <= '0;
          state      <= IDLE;
        end else if (hs) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state only, so an async reset silences the net at once.
  always_comb begin
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_src   = '0;
    bus.busy      = 1'b0;
    if (state == GRANT) begin
      bus.busy             = 1'b1;
      bus.out_src          = grant;
      bus.out_valid        = bus.req_valid[grant];
      bus.out_data         = data_arr[grant];
      bus.req_ready[grant] = bus.out_ready;
    end
  end

endmodule

// File: tb/tb_shared_driver_arbiter.sv
// Directed bench: requester queues feed the DUT, a scoreboard holds the predicted beat order.
module tb_shared_driver_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  typedef struct packed {
    logic [1:0]   src;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shared_driver_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  shared_driver_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q [$];
  logic [W:0] txq [N][$];
  int         checks   = 0;
  int         failures = 0;
  int         hsi      = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int src, input logic [W-1:0] data, input logic last);
    txq[src].push_back({last, data});
  endtask

  task automatic expect_beat(input int src, input logic [W-1:0] data);
    exp_t e;
    e.src  = 2'(src);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    logic [N-1:0][W-1:0] d;
    logic [N-1:0]        v;
    logic [N-1:0]        l;
    d = '0;
    v = '0;
    l = '0;
    for (int i = 0; i < N; i++) begin
      if (txq[i].size() > 0) begin
        v[i] = 1'b1;
        d[i] = txq[i][0][W-1:0];
        l[i] = txq[i][0][W];
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
  endtask

  // Called at the falling edge: a visible handshake will complete on the next rising edge.
  task automatic sample();
    exp_t e;
    if (hsi < 0 && bus.out_valid && bus.out_ready) begin
      hsi = int'(bus.out_src);
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_beat observed src=%0d data=%0h expected none", bus.out_src, bus.out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_src", 32'(bus.out_src), 32'(e.src));
        check("sb_data", 32'(bus.out_data), 32'(e.data));
      end
    end
  endtask

  task automatic step(input logic rdy = 1'b1);
    logic [W:0] tmp;
    @(posedge clk);
    #1;
    if (hsi >= 0) begin
      if (txq[hsi].size() > 0) tmp = txq[hsi].pop_front();
      hsi = -1;
    end
    bus.out_ready = rdy;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic run(input string tag, input int exp_cyc);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      step(1'b1);
      n++;
      done = (exp_q.size() == 0) && (hsi < 0);
      for (int i = 0; i < N; i++) if (txq[i].size() != 0) done = 1'b0;
    end
    check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_out_src",   32'(bus.out_src),   32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    rst = 1'b0;
    step();
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    // Single one-beat packet from requester 0
    load(0, 8'hA0, 1'b1); expect_beat(0, 8'hA0); drive();
    check("t1_latency", 32'(bus.out_valid), 32'd0);
    step();
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_src",   32'(bus.out_src),   32'd0);
    check("t1_busy",  32'(bus.busy),      32'd1);
    check("t1_ready", 32'(bus.req_ready), 32'b0001);
    step();
    check("t1_busy_drop",  32'(bus.busy),      32'd0);
    check("t1_ready_drop", 32'(bus.req_ready), 32'd0);

    // last_grant is now 0, so requester 1 outranks requester 0
    load(0, 8'hB0, 1'b1); load(1, 8'hB1, 1'b1);
    expect_beat(1, 8'hB1); expect_beat(0, 8'hB0); drive();
    run("t1_rr", 4);

    // Fairness from a fresh reset: 0,1,2,3,0 with an IDLE bubble after each grant
    rst = 1'b1; #1;
    check("t2_rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    load(0, 8'hC0, 1'b1); load(0, 8'hC4, 1'b1);
    load(1, 8'hC1, 1'b1); load(2, 8'hC2, 1'b1); load(3, 8'hC3, 1'b1);
    expect_beat(0, 8'hC0); expect_beat(1, 8'hC1); expect_beat(2, 8'hC2);
    expect_beat(3, 8'hC3); expect_beat(0, 8'hC4);
    drive();
    run("t2_fair", 10);

    // MAX_HOLD cap: requester 2 loses the net after 4 beats, requester 3 slips in
    for (int b = 0; b < 6; b++) load(2, 8'hD0 + 8'(b), (b == 5));
    load(3, 8'hE0, 1'b1);
    for (int b = 0; b < 4; b++) expect_beat(2, 8'hD0 + 8'(b));
    expect_beat(3, 8'hE0);
    expect_beat(2, 8'hD4); expect_beat(2, 8'hD5);
    drive();
    run("t3_cap", 10);

    // Backpressure on a 3-beat packet from requester 1
    load(1, 8'hF0, 1'b0); load(1, 8'hF1, 1'b0); load(1, 8'hF2, 1'b1);
    expect_beat(1, 8'hF0); expect_beat(1, 8'hF1); expect_beat(1, 8'hF2);
    drive();
    step(1'b1);
    check("t4_ready_hi", 32'(bus.req_ready), 32'b0010);
    check("t4_data0",    32'(bus.out_data),  32'hF0);
    step(1'b0);
    check("t4_ready_lo",  32'(bus.req_ready), 32'd0);
    check("t4_valid_stl", 32'(bus.out_valid), 32'd1);
    check("t4_data1",     32'(bus.out_data),  32'hF1);
    step(1'b0);
    check("t4_data1_hold", 32'(bus.out_data),  32'hF1);
    check("t4_busy_stl",   32'(bus.busy),      32'd1);
    step(1'b1);
    check("t4_ready_back", 32'(bus.req_ready), 32'b0010);
    step(1'b1);
    check("t4_busy_beat3", 32'(bus.busy), 32'd1);
    step(1'b1);
    check("t4_released", 32'(bus.busy),       32'd0);
    check("t4_sb_empty", 32'(exp_q.size()),   32'd0);

    // Requester 1 raises valid on the very cycle requester 0 releases
    load(0, 8'h50, 1'b1); expect_beat(0, 8'h50); drive();
    step();
    check("t5_src0", 32'(bus.out_src), 32'd0);
    load(1, 8'h51, 1'b1); expect_beat(1, 8'h51); drive();
    step();
    check("t5_bubble_busy",  32'(bus.busy),      32'd0);
    check("t5_bubble_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("t5_src1",  32'(bus.out_src), 32'd1);
    check("t5_busy1", 32'(bus.busy),    32'd1);
    step();
    check("t5_done", 32'(bus.busy), 32'd0);

    // Async reset mid-packet on requester 3, then requester 0 wins the rematch
    load(3, 8'h60, 1'b0); load(3, 8'h61, 1'b0); load(3, 8'h62, 1'b1);
    expect_beat(3, 8'h60); drive();
    step(1'b1);
    step(1'b0);
    check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    #1 bus.out_ready = 1'b1;
    #1 check("t6_pre_ready", 32'(bus.req_ready), 32'b1000);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_busy",  32'(bus.busy),      32'd0);
    check("t6_rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    txq[3].delete();
    load(3, 8'h63, 1'b1); load(0, 8'h70, 1'b1);
    expect_beat(0, 8'h70); expect_beat(3, 8'h63);
    drive();
    run("t6_rematch", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
